parity_frame_checker: RTL

Serial receive-side checker for parity-protected frames; the inverse of the team's combinational 5-input parity generator. Bits arrive LSB-first over a valid/ready stream: DATA_W data bits followed by one parity bit. Each completed frame is presented as a parallel word with a parity-error flag. It sits between a serial link front-end and downstream consumers of checked data words.

---
 rtl/parity_pkg.sv | 20 ++
 rtl/parity_acc.sv | 44 ++++
 rtl/parity_frame_checker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the serial parity frame checker and any future
// serial parity transmitter.
//   state_e  : frame-checker FSM states (DATA, PAR, HOLD)
//   PAR_EVEN : parity sense where XOR of data+parity bits must be 0
//   PAR_ODD  : parity sense where XOR of data+parity bits must be 1
// -----------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic [1:0] {
    DATA = 2'd0,  // collecting data bits
    PAR  = 2'd1,  // waiting for the parity bit
    HOLD = 2'd2   // completed frame presented downstream
  } state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// -----------------------------------------------------------------------------
// parity_acc
// Running XOR accumulator. Folds bit_i into the accumulator on every cycle
// en_i is high; clr_i returns it to 0 and takes priority over en_i.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (accumulator -> 0)
//   clr_i  : synchronous clear
//   en_i   : accumulate bit_i this cycle
//   bit_i  : bit to fold in
//   acc_o  : current XOR of all bits folded in since the last clear/reset
// -----------------------------------------------------------------------------
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic acc_o
);

  logic acc_q;
  logic acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = 1'b0;
    end else if (en_i) begin
      acc_d = acc_q ^ bit_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/parity_frame_checker.sv
// -----------------------------------------------------------------------------
// parity_frame_checker
// Serial receive-side checker for parity-protected frames. Bits arrive
// LSB-first: DATA_W data bits followed by one parity bit. Each completed frame
// is presented as a parallel word plus a parity-error flag.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid must not depend on ready. in_ready is a pure decode of the
// state register (high in DATA/PAR, low in HOLD), so there is no
// combinational path from out_ready to in_ready.
//
// Parameters:
//   DATA_W     : data bits per frame (>= 1)
//   ODD_PARITY : PAR_EVEN -> XOR of all DATA_W+1 bits must be 0,
//                PAR_ODD  -> it must be 1
//   CNT_W      : error counter width (counter build only)
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : serial bit valid          in_bit    : serial bit
//   in_ready   : checker accepts a bit
//   out_valid  : frame result valid        out_ready : consumer accepts result
//   out_data   : received data, first bit in bit 0
//   out_perr   : parity mismatch for the presented frame
//   err_clr    : synchronous clear of err_count (counter build only)
//   err_count  : saturating count of bad frames (counter build only)
//
// Build option: define PARITY_FRAME_CHECKER_ERR_CNT_EN to add err_clr /
// err_count and the saturating bad-frame counter.
// -----------------------------------------------------------------------------
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit ODD_PARITY = PAR_EVEN,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr
`ifdef PARITY_FRAME_CHECKER_ERR_CNT_EN
  ,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count
`endif
);

  // Bit index needs at least one bit even when DATA_W == 1.
  localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

  generate
    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_params
      $error("parity_frame_checker: DATA_W and CNT_W must be >= 1");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;

  logic bit_fire;
  logic res_fire;
  logic acc;
  logic acc_en;
  logic acc_clr;

  assign bit_fire = in_valid && in_ready;
  assign res_fire = out_valid && out_ready;

  parity_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .bit_i (in_bit),
    .acc_o (acc)
  );

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    perr_d    = perr_q;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      DATA: begin
        in_ready = 1'b1;
        if (bit_fire) begin
          data_d[idx_q] = in_bit;
          acc_en        = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = PAR;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      PAR: begin
        in_ready = 1'b1;
        if (bit_fire) begin
          // Mismatch when the total XOR differs from the required sense.
          perr_d  = acc ^ in_bit ^ (ODD_PARITY == PAR_ODD);
          state_d = HOLD;
        end
      end

      HOLD: begin
        out_valid = 1'b1;
        if (res_fire) begin
          acc_clr = 1'b1;
          idx_d   = '0;
          state_d = DATA;
        end
      end

      default: begin
        state_d = DATA;
        idx_d   = '0;
        acc_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DATA;
      idx_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
    end
  end

  // data_q is only written in DATA, so it is frozen while the frame is held.
  assign out_data = data_q;
  assign out_perr = perr_q;

`ifdef PARITY_FRAME_CHECKER_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;

  // Counts on the parity-bit handshake, i.e. the edge on which out_valid rises.
  assign cnt_inc = (state_q == PAR) && bit_fire && perr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_count = cnt_q;
`endif

endmodule
